// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Optional checksum trailer is enabled by defining IM_LOADER_CHECKSUM_EN.
package im_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned HDR_BYTES      = 2;

  typedef logic [2:0] state_t;

  localparam state_t HDR_HI = 3'd0;
  localparam state_t HDR_LO = 3'd1;
  localparam state_t DATA   = 3'd2;
  localparam state_t CSUM   = 3'd3;
  localparam state_t DONE   = 3'd4;
  localparam state_t ERR    = 3'd5;

endpackage

// File: rtl/im_word_packer.sv
// Assembles little-endian words from accepted data bytes; also keeps the
// running XOR of data bytes when IM_LOADER_CHECKSUM_EN is defined.
module im_word_packer
  import im_loader_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_en,
  input  logic [7:0]        byte_in,
  output logic              word_done,
  output logic [DATA_W-1:0] word_data
`ifdef IM_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]        xor_acc
`endif
);

  logic [1:0]        cnt;
  logic [DATA_W-9:0] shreg;

  // Only the first three bytes are stored; the fourth is merged combinationally
  // so the word is ready on the same edge that accepts its last byte.
  assign word_done = byte_en && (cnt == 2'(BYTES_PER_WORD - 1));
  assign word_data = {byte_in, shreg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (byte_en) begin
      cnt   <= cnt + 2'd1;
      shreg <= {byte_in, shreg[DATA_W-9:8]};
    end
  end

`ifdef IM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xor_acc <= '0;
    end else if (byte_en) begin
      xor_acc <= xor_acc ^ byte_in;
    end
  end
`endif

endmodule

// File: rtl/im_loader.sv
// Boot-time IM loader: framed byte stream in, sequential IM word writes out,
// processor held in reset until the image is complete (IM_LOADER_CHECKSUM_EN adds a trailer check).
module im_loader
  import im_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

`ifdef IM_LOADER_CHECKSUM_EN
  localparam state_t FRAME_END = CSUM;
  logic [7:0] xor_acc;
`else
  localparam state_t FRAME_END = DONE;
`endif

  state_t            state;
  logic [7:0]        n_hi;
  logic [15:0]       n_words;
  logic [ADDR_W-1:0] widx;
  logic              accept;
  logic              data_en;
  logic              word_done;
  logic [DATA_W-1:0] word_data;
  logic [15:0]       n_full;
  logic              n_oversize;
  logic              last_word;

  assign in_ready   = (state == HDR_HI) || (state == HDR_LO) ||
                      (state == DATA)   || (state == CSUM);
  assign accept     = in_valid && in_ready;
  assign data_en    = accept && (state == DATA);
  assign n_full     = {n_hi, in_byte};
  assign n_oversize = 32'(n_full) > (32'd1 << ADDR_W);
  assign last_word  = (32'(widx) + 32'd1) == 32'(n_words);

  assign done     = (state == DONE);
  assign error    = (state == ERR);
  assign cpu_hold = (state != DONE);

  im_word_packer #(
    .DATA_W (DATA_W)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .byte_en   (data_en),
    .byte_in   (in_byte),
    .word_done (word_done),
    .word_data (word_data)
`ifdef IM_LOADER_CHECKSUM_EN
    ,
    .xor_acc   (xor_acc)
`endif
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= HDR_HI;
      n_hi     <= '0;
      n_words  <= '0;
      widx     <= '0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
    end else begin
      im_we <= word_done;
      if (word_done) begin
        im_addr  <= widx;
        im_wdata <= word_data;
        widx     <= widx + ADDR_W'(1);
      end

      case (state)
        HDR_HI: begin
          if (accept) begin
            n_hi  <= in_byte;
            state <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (accept) begin
            n_words <= n_full;
            if (n_oversize)        state <= ERR;
            else if (n_full == '0) state <= FRAME_END;
            else                   state <= DATA;
          end
        end
        DATA: begin
          if (word_done && last_word) state <= FRAME_END;
        end
`ifdef IM_LOADER_CHECKSUM_EN
        CSUM: begin
          if (accept) state <= (in_byte == xor_acc) ? DONE : ERR;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: table of frames plus hand-written
// reset-mid-frame sequence; IM writes checked against a scoreboard queue.
module tb_im_loader;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
`ifdef IM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_byte = '0;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [DATA_W-1:0] im_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  always #5 clk = ~clk;

  im_loader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_byte  (in_byte),
    .in_ready (in_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  typedef struct {
    logic [15:0]      n;
    logic [2:0][31:0] w;
    logic [7:0]       csum_delta;
    bit               gaps;
    bit               exp_err;
    int               exp_writes;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[7];
  int   checks = 0;
  int   failures = 0;
  int   we_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write monitor: im_we is sampled mid-cycle so each one-cycle pulse is seen once.
  always @(negedge clk) begin
    wr_t e;
    if (im_we === 1'b1) begin
      we_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", im_addr, im_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(im_addr), 32'(e.addr));
        check("wr_data", im_wdata, e.data);
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_im_we"},    32'(im_we),    32'd0);
    check({tag, "_im_addr"},  32'(im_addr),  32'd0);
    check({tag, "_im_wdata"}, im_wdata,      32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_done"},     32'(done),     32'd0);
    check({tag, "_error"},    32'(error),    32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check_reset_values("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    check("in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_byte  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    logic [7:0] x;
    logic [7:0] b;
    x = '0;
    do_reset();
    we_count = 0;
    send_byte(v.n[15:8], v.gaps);
    send_byte(v.n[7:0], v.gaps);
    if (32'(v.n) > (32'd1 << ADDR_W)) begin
      check("oversize_error", 32'(error), 32'd1);
      check("oversize_ready", 32'(in_ready), 32'd0);
      check("oversize_hold", 32'(cpu_hold), 32'd1);
    end else begin
      for (int i = 0; i < int'(v.n); i++) begin
        for (int j = 0; j < 4; j++) begin
          b = v.w[i][8*j +: 8];
          x = x ^ b;
          if (j == 3) exp_q.push_back('{addr: ADDR_W'(i), data: v.w[i]});
          send_byte(b, v.gaps);
        end
      end
`ifdef IM_LOADER_CHECKSUM_EN
      send_byte(x ^ v.csum_delta, v.gaps);
`else
      if (v.n != 16'd0) check("we_with_done", 32'(im_we), 32'd1);
`endif
      check("frame_end", 32'(done | error), 32'd1);
    end
    repeat (3) @(negedge clk);
    // Bytes offered in a terminal state must be ignored.
    in_valid = 1'b1;
    in_byte  = 8'hFF;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check("done",     32'(done),     32'(!v.exp_err));
    check("error",    32'(error),    32'(v.exp_err));
    check("cpu_hold", 32'(cpu_hold), 32'(v.exp_err));
    check("ready_end", 32'(in_ready), 32'd0);
    check("we_count", 32'(we_count), 32'(v.exp_writes));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] x;
    logic [7:0] fb[6];

    vecs[0] = '{n: 16'd2, w: {32'h0, 32'hDEADBEEF, 32'h12345678}, csum_delta: 8'h00,
                gaps: 1'b0, exp_err: 1'b0, exp_writes: 2};
    vecs[1] = '{n: 16'd2, w: {32'h0, 32'hDEADBEEF, 32'h12345678}, csum_delta: 8'h00,
                gaps: 1'b1, exp_err: 1'b0, exp_writes: 2};
    vecs[2] = '{n: 16'h0401, w: '0, csum_delta: 8'h00,
                gaps: 1'b0, exp_err: 1'b1, exp_writes: 0};
    vecs[3] = '{n: 16'd0, w: '0, csum_delta: 8'h00,
                gaps: 1'b0, exp_err: 1'b0, exp_writes: 0};
    vecs[4] = '{n: 16'd1, w: {32'h0, 32'h0, 32'h04030201}, csum_delta: 8'h01,
                gaps: 1'b0, exp_err: CSUM_EN, exp_writes: 1};
    vecs[5] = '{n: 16'd1, w: {32'h0, 32'h0, 32'h04030201}, csum_delta: 8'h00,
                gaps: 1'b0, exp_err: 1'b0, exp_writes: 1};
    vecs[6] = '{n: 16'd3, w: {32'hA5A55A5A, 32'hFFFFFFFF, 32'h00000000}, csum_delta: 8'h00,
                gaps: 1'b1, exp_err: 1'b0, exp_writes: 3};

    for (int k = 0; k < 7; k++) run_frame(vecs[k]);

    // Reset after six data bytes of a two-word frame, then reload one word.
    do_reset();
    we_count = 0;
    fb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) exp_q.push_back('{addr: '0, data: 32'h44332211});
      send_byte(fb[i], 1'b0);
    end
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    rst = 1'b0;
    x = 8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD;
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    exp_q.push_back('{addr: '0, data: 32'hDDCCBBAA});
    send_byte(8'hDD, 1'b0);
`ifdef IM_LOADER_CHECKSUM_EN
    send_byte(x, 1'b0);
`endif
    repeat (3) @(negedge clk);
    check("reload_done", 32'(done), 32'd1);
    check("reload_hold", 32'(cpu_hold), 32'd0);
    check("reload_we_count", 32'(we_count), 32'd2);
    check("reload_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
